// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// fft_pkg
// Shared widths, Q1.14 twiddles, bit-reverse table, state encoding and
// butterfly indexing helpers for the 16-point FFT engine.
// Revision: 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int C_N   = 16;
    localparam int C_SW  = 18;
    localparam int C_OW  = 24;
    localparam int C_TWF = 14;
    localparam int C_TWW = 16;
    localparam int C_BW  = C_SW + 4;          // one growth bit per stage
    localparam int C_PW  = C_BW + C_TWW + 1;  // sum of two complex partial products

    // W16^k, k = 0..7: re = round(16384*cos), im = round(-16384*sin)
    localparam logic signed [C_TWW-1:0] C_TW_RE [8] = '{
        16'sd16384,  16'sd15137,  16'sd11585,  16'sd6270,
        16'sd0,     -16'sd6270,  -16'sd11585, -16'sd15137 };
    localparam logic signed [C_TWW-1:0] C_TW_IM [8] = '{
        16'sd0,     -16'sd6270,  -16'sd11585, -16'sd15137,
       -16'sd16384, -16'sd15137, -16'sd11585, -16'sd6270 };

    localparam logic [3:0] C_BITREV [C_N] = '{
        4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
        4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15 };

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        S4   = 3'd4,
        MAG  = 3'd5
    } state_t;

    // Upper-leg bank index of butterfly j in a stage of span 2^lg.
    function automatic logic [3:0] bf_top(input logic [2:0] j, input logic [1:0] lg);
        logic [3:0] mask;
        logic [3:0] jj;
        mask = (4'd1 << lg) - 4'd1;
        jj   = {1'b0, j};
        return ((jj & ~mask) << 1) | (jj & mask);
    endfunction

    // Twiddle exponent of butterfly j in a stage of span 2^lg.
    function automatic logic [2:0] bf_tw(input logic [2:0] j, input logic [1:0] lg);
        logic [2:0] mask;
        mask = (3'd1 << lg) - 3'd1;
        return (j & mask) << (2'd3 - lg);
    endfunction

    function automatic logic [C_OW-1:0] bin_mag(input logic signed [C_BW-1:0] re,
                                                input logic signed [C_BW-1:0] im);
        logic [C_BW-1:0] are;
        logic [C_BW-1:0] aim;
        are = re[C_BW-1] ? C_BW'(-re) : C_BW'(re);
        aim = im[C_BW-1] ? C_BW'(-im) : C_BW'(im);
        return C_OW'(are) + C_OW'(aim);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_butterfly.sv
`default_nettype none
// ============================================================================
// fft_butterfly
// Combinational radix-2 DIT butterfly: a' = a + W*b, b' = a - W*b.
// FFT_ROUND_EN selects round-half-up on the Q1.14 product (default: truncate).
// Revision: 1.0 - initial release
// ============================================================================
module fft_butterfly
    import fft_pkg::*;
(
    input  logic signed [C_BW-1:0] i_a_re,
    input  logic signed [C_BW-1:0] i_a_im,
    input  logic signed [C_BW-1:0] i_b_re,
    input  logic signed [C_BW-1:0] i_b_im,
    input  logic        [2:0]      i_tw,
    output logic signed [C_BW-1:0] o_a_re,
    output logic signed [C_BW-1:0] o_a_im,
    output logic signed [C_BW-1:0] o_b_re,
    output logic signed [C_BW-1:0] o_b_im
);

`ifdef FFT_ROUND_EN
    localparam logic signed [C_PW-1:0] C_RND = C_PW'(1) << (C_TWF - 1);
`else
    localparam logic signed [C_PW-1:0] C_RND = '0;
`endif

    logic signed [C_PW-1:0] w_br, w_bi, w_wr, w_wi, w_pr, w_pi;
    logic signed [C_BW-1:0] w_qr, w_qi;

    always_comb begin
        w_br = C_PW'(i_b_re);
        w_bi = C_PW'(i_b_im);
        w_wr = C_PW'(C_TW_RE[i_tw]);
        w_wi = C_PW'(C_TW_IM[i_tw]);
        w_pr = w_br * w_wr - w_bi * w_wi + C_RND;
        w_pi = w_br * w_wi + w_bi * w_wr + C_RND;
        // |W*b| never exceeds |b|, so the shifted product fits the bank width
        w_qr = C_BW'(w_pr >>> C_TWF);
        w_qi = C_BW'(w_pi >>> C_TWF);
    end

    assign o_a_re = i_a_re + w_qr;
    assign o_a_im = i_a_im + w_qi;
    assign o_b_re = i_a_re - w_qr;
    assign o_b_im = i_a_im - w_qi;

endmodule
`default_nettype wire

// File: rtl/fft_processor.sv
`default_nettype none
// ============================================================================
// fft_processor
// 16-point iterative radix-2 DIT FFT: capture, four butterfly stages, then
// |Re|+|Im| magnitudes with a one-cycle done pulse. Rounding via FFT_ROUND_EN.
// Revision: 1.0 - initial release
// ============================================================================
module fft_processor
    import fft_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   new_t,
    input  logic signed [C_SW-1:0] t0, t1, t2, t3, t4, t5, t6, t7,
    input  logic signed [C_SW-1:0] t8, t9, t10, t11, t12, t13, t14, t15,
    output logic        [C_OW-1:0] f0, f1, f2, f3, f4, f5, f6, f7,
    output logic        [C_OW-1:0] f8, f9, f10, f11, f12, f13, f14, f15,
    output logic                   done
);

    state_t                 r_state, w_state_nxt;
    logic [1:0]             w_lg;
    logic signed [C_SW-1:0] w_t  [C_N];
    logic signed [C_BW-1:0] r_re [C_N];
    logic signed [C_BW-1:0] r_im [C_N];
    logic [C_OW-1:0]        r_f  [C_N];
    logic                   r_done;
    logic [3:0]             w_ia [8];
    logic [3:0]             w_ib [8];
    logic [2:0]             w_k  [8];
    logic signed [C_BW-1:0] w_ar [8], w_ai [8], w_br [8], w_bi [8];

    always_comb begin
        w_t = '{t0, t1, t2, t3, t4, t5, t6, t7, t8, t9, t10, t11, t12, t13, t14, t15};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lg        = 2'd0;
        case (r_state)
            IDLE: if (new_t) w_state_nxt = S1;
            S1:   begin w_lg = 2'd0; w_state_nxt = S2;  end
            S2:   begin w_lg = 2'd1; w_state_nxt = S3;  end
            S3:   begin w_lg = 2'd2; w_state_nxt = S4;  end
            S4:   begin w_lg = 2'd3; w_state_nxt = MAG; end
            MAG:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Eight butterflies share the bank; operand selection follows the stage span.
    for (genvar j = 0; j < 8; j++) begin : g_bfly
        assign w_ia[j] = bf_top(3'(j), w_lg);
        assign w_ib[j] = w_ia[j] | (4'd1 << w_lg);
        assign w_k[j]  = bf_tw(3'(j), w_lg);

        fft_butterfly u_bfly (
            .i_a_re (r_re[w_ia[j]]),
            .i_a_im (r_im[w_ia[j]]),
            .i_b_re (r_re[w_ib[j]]),
            .i_b_im (r_im[w_ib[j]]),
            .i_tw   (w_k[j]),
            .o_a_re (w_ar[j]),
            .o_a_im (w_ai[j]),
            .o_b_re (w_br[j]),
            .o_b_im (w_bi[j])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done <= 1'b0;
            for (int i = 0; i < C_N; i++) begin
                r_re[i] <= '0;
                r_im[i] <= '0;
                r_f[i]  <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (new_t) begin
                    for (int i = 0; i < C_N; i++) begin
                        r_re[i] <= C_BW'(w_t[C_BITREV[i]]);
                        r_im[i] <= '0;
                    end
                end
                S1, S2, S3, S4: begin
                    for (int j = 0; j < 8; j++) begin
                        r_re[w_ia[j]] <= w_ar[j];
                        r_im[w_ia[j]] <= w_ai[j];
                        r_re[w_ib[j]] <= w_br[j];
                        r_im[w_ib[j]] <= w_bi[j];
                    end
                end
                MAG: begin
                    for (int i = 0; i < C_N; i++) r_f[i] <= bin_mag(r_re[i], r_im[i]);
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done = r_done;
    assign f0  = r_f[0];   assign f1  = r_f[1];   assign f2  = r_f[2];   assign f3  = r_f[3];
    assign f4  = r_f[4];   assign f5  = r_f[5];   assign f6  = r_f[6];   assign f7  = r_f[7];
    assign f8  = r_f[8];   assign f9  = r_f[9];   assign f10 = r_f[10];  assign f11 = r_f[11];
    assign f12 = r_f[12];  assign f13 = r_f[13];  assign f14 = r_f[14];  assign f15 = r_f[15];

endmodule
`default_nettype wire

// File: tb/tb_fft_processor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_fft_processor
// Scoreboard bench for fft_processor: expected bins are queued at capture and
// compared, together with the capture-to-done latency, on each done pulse.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fft_processor;

    typedef logic [15:0][23:0] bins_t;
    typedef logic [15:0][17:0] frame_t;
    typedef struct {
        bins_t       f;
        logic [15:0] m;
        int          start;
    } exp_t;

    logic               clk   = 1'b0;
    logic               reset = 1'b1;
    logic               new_t = 1'b0;
    logic signed [17:0] ti [16];
    logic        [23:0] fo [16];
    logic               done;
    int                 cyc      = 0;
    int                 n_vec    = 0;
    int                 n_miscmp = 0;
    exp_t               sbq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_processor dut (
        .clk   (clk),    .reset (reset),  .new_t (new_t),
        .t0  (ti[0]),  .t1  (ti[1]),  .t2  (ti[2]),  .t3  (ti[3]),
        .t4  (ti[4]),  .t5  (ti[5]),  .t6  (ti[6]),  .t7  (ti[7]),
        .t8  (ti[8]),  .t9  (ti[9]),  .t10 (ti[10]), .t11 (ti[11]),
        .t12 (ti[12]), .t13 (ti[13]), .t14 (ti[14]), .t15 (ti[15]),
        .f0  (fo[0]),  .f1  (fo[1]),  .f2  (fo[2]),  .f3  (fo[3]),
        .f4  (fo[4]),  .f5  (fo[5]),  .f6  (fo[6]),  .f7  (fo[7]),
        .f8  (fo[8]),  .f9  (fo[9]),  .f10 (fo[10]), .f11 (fo[11]),
        .f12 (fo[12]), .f13 (fo[13]), .f14 (fo[14]), .f15 (fo[15]),
        .done  (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // |round(16384*cos)| + |round(16384*sin)| of W16^k
    function automatic int tw_mag(input int k);
        real c, s;
        c = $floor(16384.0 * $cos(6.283185307179586 * k / 16.0) + 0.5);
        s = $floor(16384.0 * $sin(6.283185307179586 * k / 16.0) + 0.5);
        return $rtoi((c < 0.0 ? -c : c) + (s < 0.0 ? -s : s));
    endfunction

    task automatic push_exp(input bins_t ef, input logic [15:0] em);
        exp_t e;
        e.f     = ef;
        e.m     = em;
        e.start = cyc;
        sbq.push_back(e);
    endtask

    // Returns #1 after the capture edge with new_t already dropped.
    task automatic drive(input frame_t s, input bins_t ef, input logic [15:0] em,
                         input bit expect_out);
        @(negedge clk);
        for (int k = 0; k < 16; k++) ti[k] = s[k];
        new_t = 1'b1;
        @(posedge clk);
        #1;
        if (expect_out) push_exp(ef, em);
        new_t = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            chk("timeout_pending_frames", sbq.size(), 0);
            sbq.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("latency", cyc - e.start, 5);
                for (int k = 0; k < 16; k++)
                    if (e.m[k]) chk($sformatf("f%0d", k), fo[k], e.f[k]);
            end
        end
    end

    initial begin
        frame_t      s;
        bins_t       ef;
        logic [15:0] em;

        for (int k = 0; k < 16; k++) ti[k] = '0;
        #2 reset = 1'b0;
        #10;
        chk("rst_done", done, 0);
        for (int k = 0; k < 16; k++) chk($sformatf("rst_f%0d", k), fo[k], 0);
        @(negedge clk) reset = 1'b1;

        // impulse at t0: flat spectrum
        s = '0; s[0] = 18'sd511;
        for (int k = 0; k < 16; k++) ef[k] = 24'd511;
        em = '1;
        drive(s, ef, em, 1'b1);
        wait_idle(20);

        // DC
        for (int k = 0; k < 16; k++) s[k] = 18'sd100;
        ef = '0; ef[0] = 24'd1600;
        drive(s, ef, em, 1'b1);
        wait_idle(20);

        // Nyquist
        for (int k = 0; k < 16; k++) s[k] = (k % 2 == 0) ? 18'sd256 : -18'sd256;
        ef = '0; ef[8] = 24'd4096;
        drive(s, ef, em, 1'b1);
        wait_idle(20);

        // delayed impulse: every bin carries a full-scale twiddle magnitude
        s = '0; s[1] = 18'sd16384;
        for (int k = 0; k < 16; k++) ef[k] = 24'(tw_mag(k));
        drive(s, ef, em, 1'b1);
        wait_idle(20);

        // block pattern, inputs scrambled after capture, new_t pulse while in S2
        for (int k = 0; k < 16; k++)
            s[k] = (k < 4) ? 18'sd511 : ((k >= 8 && k < 12) ? -18'sd512 : 18'sd0);
        ef = '0; ef[0] = 24'd4;
        em = 16'h1111;
        drive(s, ef, em, 1'b1);
        for (int k = 0; k < 16; k++) ti[k] = 18'($urandom);
        @(posedge clk); #1;
        new_t = 1'b1;
        @(posedge clk); #1;
        new_t = 1'b0;
        wait_idle(20);

        // new_t held for 20 cycles: one DC frame every 6 cycles
        for (int k = 0; k < 16; k++) s[k] = 18'sd100;
        ef = '0; ef[0] = 24'd1600;
        em = '1;
        @(negedge clk);
        for (int k = 0; k < 16; k++) ti[k] = s[k];
        new_t = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i % 6 == 0) push_exp(ef, em);
        end
        new_t = 1'b0;
        wait_idle(40);

        // reset during S3 aborts the frame
        s = '0; s[0] = 18'sd511;
        drive(s, ef, em, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("abort_done", done, 0);
        for (int k = 0; k < 16; k++) chk($sformatf("abort_f%0d", k), fo[k], 0);
        repeat (2) @(posedge clk);
        #1 chk("abort_hold_done", done, 0);
        @(negedge clk) reset = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("abort_no_done", done, 0);

        for (int k = 0; k < 16; k++) ef[k] = 24'd511;
        drive(s, ef, em, 1'b1);
        wait_idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
